time_stamp_tx: RTL and testbench
================================

# time_stamp_tx

Serial time-stamp transmitter for the century clock. On a request pulse it snapshots the clock's BCD time/date fields and sends them as the ASCII line `YYYY-MM-DD hh:mm:ss\r\n` over a UART 8N1 output. The clock counters write the time; this block reads it out to an external host. It sits beside the display path, on the 50 MHz system clock, and only reads the counter outputs.

## Interface
- `F_IN`, default 50_000_000: input clock frequency in Hz.
- `BAUD`, default 115_200: line rate. Bit period `DIV = F_IN / BAUD`, truncating integer division (434 at defaults). `DIV` must be ≥ 2.

Ports:
- `clk` in 1: system clock. One clock domain only.
- `rst_n` in 1: reset, asynchronous, active-low.
- `send` in 1: request pulse. It is sampled on every `clk` edge.
- `sec_unit`, `sec_ten`, `min_unit`, `min_ten` in 4 each: BCD seconds and minutes.
- `hour_unit` in 4, `hour_ten` in 2: BCD hour.
- `day_unit` in 4, `day_ten` in 2: BCD day.
- `month_unit` in 4, `month_ten` in 2: BCD month.
- `year_thou`, `year_hund`, `year_ten`, `year_unit` in 4 each: BCD year.
- `tx` out 1: UART line. Idle level is high.
- `busy` out 1: high while a frame is in progress.
- `done` out 1: one-cycle pulse marking the end of a frame.

## Operation
- **Frame content:** 21 characters, sent in this order:
  - the 4 year digits;
  - `-` (0x2D), 2 month digits, `-`, 2 day digits;
  - space (0x20);
  - hh, `:` (0x3A), mm, `:`, ss;
  - CR (0x0D), LF (0x0A).
- **Digit encoding:** each digit is sent as `8'h30 | {4'b0, nibble}`. Two-bit ten fields are zero-extended first. A non-BCD nibble (A–F) is sent as-is, giving 0x3A–0x3F; there is no checking.
- **Character format:** start bit (0), 8 data bits LSB first, stop bit (1). Each bit lasts exactly `DIV` cycles. There is no idle gap between characters inside a frame.
- **Snapshot:** all BCD inputs are registered on the accepting edge. Input changes after that edge do not affect the frame in progress.
- **FSM states:** IDLE, START, DATA, STOP.
  - IDLE → START when `send`=1 and `busy`=0.
  - START → DATA after `DIV` cycles.
  - DATA → STOP after 8 bit periods.
  - STOP → START when character index < 20, with the index incremented.
  - STOP → IDLE when the index is 20.
- **Counters:**
  - baud counter, 0..DIV-1;
  - bit index, 0..7;
  - character index, 0..20, 5 bits.
- **Request handling:**
  - `send` while `busy`=1 is ignored. Requests are not queued.
  - `send` held high for several cycles in IDLE starts exactly one frame per acceptance. If it is still high on the first IDLE cycle after a frame, a new frame starts.

## Timing
- **Reset values:** `tx`=1, `busy`=0, `done`=0, state IDLE, all counters 0. Reset assertion mid-frame forces these values immediately. After release the block stays idle until a new `send`.
- **Start of frame:** `send` sampled high at edge N with `busy`=0. At N, `busy`→1, the snapshot is taken and `tx`→0. The start bit then spans edges N..N+DIV.
- **End of frame:** the frame lasts 21×10×DIV cycles from edge N. At edge N+210·DIV, `tx` stays 1, `busy`→0 and `done`→1 for exactly one cycle.
- **Back-to-back frames:** a `send` high during the `done` cycle is accepted at the next edge. The gap between frames is therefore exactly one idle-high cycle beyond the stop bit.
- **Registered outputs:** `tx`, `busy` and `done` are registered, so there are no glitches.

## Structure
- **Shared package `century_pkg`:**
  - ASCII constants: `ASC_0`, `ASC_DASH`, `ASC_COLON`, `ASC_SPACE`, `ASC_CR`, `ASC_LF`;
  - `TS_FRAME_LEN` = 21;
  - function `bcd_to_ascii(nibble)`.
- **Sub-module `uart_tx_byte`:**
  - parameter `DIV`;
  - ports `clk`, `rst_n`, `load`, `data[7:0]`, `tx`, `ready`;
  - contains the baud counter, the bit index and the 10-bit shift register.
- **Top level:** owns the snapshot registers, the character-index sequencer and the character multiplexer, plus `busy`/`done`.

## Test plan
Benches run with `F_IN`=16, `BAUD`=1, giving `DIV`=16.
1. **Reset:** assert `rst_n`=0 → `tx`=1, `busy`=0, `done`=0. Hold idle for 100 cycles → `tx` stays 1.
2. **Full frame:** time 2024-02-29 23:59:58, one-cycle `send` → the line decodes `2024-02-29 23:59:58\r\n`. `busy` is high for exactly 3360 cycles, then `done` is a single-cycle pulse.
3. **Snapshot:** after acceptance, change `sec_unit` to 9 and `year_unit` to 5 at cycle 50 → the frame still ends in `58` and the year is still `2024`.
4. **Request handling:**
   - `send` pulsed at cycles 100 and 2000 of a frame → exactly one frame is sent.
   - `send` during the `done` cycle → the next start bit begins after exactly 1 idle cycle.
5. **Reset mid-frame:** `rst_n` low in the middle of a DATA bit of character 7 → `tx`=1 and `busy`=0 with no clock edge. After release, no activity occurs until the next `send`.
6. **Bit timing and non-BCD digits:**
   - Every bit of the first character lasts exactly 16 cycles.
   - `min_ten`=4'hC → that character decodes as 0x3C (`<`).

Source files
------------

// File: rtl/century_pkg.sv
// Shared definitions for the century clock: ASCII constants, time-stamp frame
// layout and the transmitter's line-state encoding.
package century_pkg;

    localparam logic [7:0] ASC_0     = 8'h30;
    localparam logic [7:0] ASC_DASH  = 8'h2D;
    localparam logic [7:0] ASC_COLON = 8'h3A;
    localparam logic [7:0] ASC_SPACE = 8'h20;
    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_LF    = 8'h0A;

    localparam int TS_FRAME_LEN = 21;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_t;

    typedef struct packed {
        logic [3:0] year_thou;
        logic [3:0] year_hund;
        logic [3:0] year_ten;
        logic [3:0] year_unit;
        logic [1:0] month_ten;
        logic [3:0] month_unit;
        logic [1:0] day_ten;
        logic [3:0] day_unit;
        logic [1:0] hour_ten;
        logic [3:0] hour_unit;
        logic [3:0] min_ten;
        logic [3:0] min_unit;
        logic [3:0] sec_ten;
        logic [3:0] sec_unit;
    } ts_snap_t;

    // Non-BCD nibbles pass straight through (A-F become 0x3A-0x3F).
    function automatic logic [7:0] bcd_to_ascii(input logic [3:0] nibble);
        return ASC_0 | {4'b0, nibble};
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// UART 8N1 byte transmitter. A load in the last stop-bit cycle chains the next
// character with no idle gap.
module uart_tx_byte
    import century_pkg::*;
#(
    parameter int DIV = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] data,
    output logic       tx,
    output logic       ready
);

    localparam int CW = $clog2(DIV);

    tx_state_t     state, state_nxt;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [9:0]    shreg;
    logic          bit_end;

    assign bit_end = (baud_cnt == CW'(DIV - 1));
    assign ready   = (state == ST_IDLE) || (state == ST_STOP && bit_end);
    assign tx      = shreg[0];

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (load) state_nxt = ST_START;
            ST_START: if (bit_end) state_nxt = ST_DATA;
            ST_DATA:  if (bit_end && bit_idx == 3'd7) state_nxt = ST_STOP;
            ST_STOP:  if (bit_end) state_nxt = load ? ST_START : ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Shift register idles at all ones so tx rests high; ones shift in behind data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg    <= '1;
            baud_cnt <= '0;
            bit_idx  <= '0;
        end else if (load && ready) begin
            shreg    <= {1'b1, data, 1'b0};
            baud_cnt <= '0;
            bit_idx  <= '0;
        end else if (state != ST_IDLE) begin
            if (bit_end) begin
                baud_cnt <= '0;
                shreg    <= {1'b1, shreg[9:1]};
                if (state == ST_DATA) bit_idx <= bit_idx + 3'd1;
            end else begin
                baud_cnt <= baud_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/time_stamp_tx.sv
// Time-stamp transmitter: snapshots the BCD clock fields on a send request and
// emits "YYYY-MM-DD hh:mm:ss\r\n" over UART 8N1.
module time_stamp_tx
    import century_pkg::*;
#(
    parameter int F_IN = 50_000_000,
    parameter int BAUD = 115_200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       send,
    input  logic [3:0] sec_unit,
    input  logic [3:0] sec_ten,
    input  logic [3:0] min_unit,
    input  logic [3:0] min_ten,
    input  logic [3:0] hour_unit,
    input  logic [1:0] hour_ten,
    input  logic [3:0] day_unit,
    input  logic [1:0] day_ten,
    input  logic [3:0] month_unit,
    input  logic [1:0] month_ten,
    input  logic [3:0] year_thou,
    input  logic [3:0] year_hund,
    input  logic [3:0] year_ten,
    input  logic [3:0] year_unit,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int         DIV      = F_IN / BAUD;
    localparam logic [4:0] LAST_IDX = 5'(TS_FRAME_LEN - 1);

    ts_snap_t   live, snap, src;
    logic [4:0] char_idx, sel_idx;
    logic [7:0] char_data;
    logic       accept, advance, load, ready;

    assign live = {year_thou, year_hund, year_ten, year_unit, month_ten, month_unit,
                   day_ten, day_unit, hour_ten, hour_unit, min_ten, min_unit,
                   sec_ten, sec_unit};

    assign accept  = send && !busy;
    assign advance = busy && ready;
    assign load    = accept || (advance && char_idx != LAST_IDX);

    // The first character loads on the accepting edge, before the snapshot lands.
    assign src     = busy ? snap : live;
    assign sel_idx = accept ? 5'd0 : char_idx + 5'd1;

    always_comb begin
        char_data = ASC_LF;
        unique case (sel_idx)
            5'd0:    char_data = bcd_to_ascii(src.year_thou);
            5'd1:    char_data = bcd_to_ascii(src.year_hund);
            5'd2:    char_data = bcd_to_ascii(src.year_ten);
            5'd3:    char_data = bcd_to_ascii(src.year_unit);
            5'd4:    char_data = ASC_DASH;
            5'd5:    char_data = bcd_to_ascii({2'b0, src.month_ten});
            5'd6:    char_data = bcd_to_ascii(src.month_unit);
            5'd7:    char_data = ASC_DASH;
            5'd8:    char_data = bcd_to_ascii({2'b0, src.day_ten});
            5'd9:    char_data = bcd_to_ascii(src.day_unit);
            5'd10:   char_data = ASC_SPACE;
            5'd11:   char_data = bcd_to_ascii({2'b0, src.hour_ten});
            5'd12:   char_data = bcd_to_ascii(src.hour_unit);
            5'd13:   char_data = ASC_COLON;
            5'd14:   char_data = bcd_to_ascii(src.min_ten);
            5'd15:   char_data = bcd_to_ascii(src.min_unit);
            5'd16:   char_data = ASC_COLON;
            5'd17:   char_data = bcd_to_ascii(src.sec_ten);
            5'd18:   char_data = bcd_to_ascii(src.sec_unit);
            5'd19:   char_data = ASC_CR;
            default: char_data = ASC_LF;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            char_idx <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                snap     <= live;
                busy     <= 1'b1;
                char_idx <= '0;
            end else if (advance) begin
                if (char_idx == LAST_IDX) begin
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    char_idx <= '0;
                end else begin
                    char_idx <= char_idx + 5'd1;
                end
            end
        end
    end

    uart_tx_byte #(.DIV(DIV)) u_uart (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .data  (char_data),
        .tx    (tx),
        .ready (ready)
    );

endmodule

// File: tb/tb_time_stamp_tx.sv
// Bench for time_stamp_tx at DIV=16: a UART monitor decodes the line and checks
// each character against a queue of expected characters pushed at request time.
module tb_time_stamp_tx;

    localparam int DIV = 16;

    logic       clk = 1'b0, rst_n = 1'b0, send = 1'b0;
    logic [3:0] sec_unit, sec_ten, min_unit, min_ten, hour_unit, day_unit, month_unit;
    logic [1:0] hour_ten, day_ten, month_ten;
    logic [3:0] year_thou, year_hund, year_ten, year_unit;
    logic       tx, busy, done;

    int         n_chk = 0, n_pass = 0;
    logic [7:0] exp_q[$];
    bit         mon_en = 1'b1;

    time_stamp_tx #(.F_IN(16), .BAUD(1)) dut (
        .clk(clk), .rst_n(rst_n), .send(send),
        .sec_unit(sec_unit), .sec_ten(sec_ten), .min_unit(min_unit), .min_ten(min_ten),
        .hour_unit(hour_unit), .hour_ten(hour_ten), .day_unit(day_unit), .day_ten(day_ten),
        .month_unit(month_unit), .month_ten(month_ten),
        .year_thou(year_thou), .year_hund(year_hund), .year_ten(year_ten), .year_unit(year_unit),
        .tx(tx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [7:0] asc(input logic [3:0] n);
        return 8'h30 + {4'b0, n};
    endfunction

    task automatic push_frame();
        exp_q.push_back(asc(year_thou)); exp_q.push_back(asc(year_hund));
        exp_q.push_back(asc(year_ten));  exp_q.push_back(asc(year_unit));
        exp_q.push_back(8'h2D);
        exp_q.push_back(asc({2'b0, month_ten})); exp_q.push_back(asc(month_unit));
        exp_q.push_back(8'h2D);
        exp_q.push_back(asc({2'b0, day_ten}));   exp_q.push_back(asc(day_unit));
        exp_q.push_back(8'h20);
        exp_q.push_back(asc({2'b0, hour_ten}));  exp_q.push_back(asc(hour_unit));
        exp_q.push_back(8'h3A);
        exp_q.push_back(asc(min_ten)); exp_q.push_back(asc(min_unit));
        exp_q.push_back(8'h3A);
        exp_q.push_back(asc(sec_ten)); exp_q.push_back(asc(sec_unit));
        exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
    endtask

    // Returns on the negedge just after the accepting posedge.
    task automatic pulse_send();
        @(negedge clk); send = 1'b1;
        @(negedge clk); send = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int c = 0;
        while (busy === 1'b1 && c < bound) begin
            @(negedge clk);
            c++;
        end
        check("frame_timeout", {31'b0, busy}, 32'd0);
    endtask

    // Line monitor: samples mid-bit on negedges and scores each decoded character.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (mon_en && rst_n && tx === 1'b0) begin
                repeat (DIV / 2) @(negedge clk);
                check("start_bit", {31'b0, tx}, 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (DIV) @(negedge clk);
                    b[i] = tx;
                end
                repeat (DIV) @(negedge clk);
                check("stop_bit", {31'b0, tx}, 32'd1);
                check("char_pending", {31'b0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) check("char", {24'b0, b}, {24'b0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish, expected finish before 5 ms");
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [159:0] wave;
        logic [9:0]   frm;
        bit           ok;
        int           cnt;

        year_thou = 4'd2; year_hund = 4'd0; year_ten = 4'd2; year_unit = 4'd4;
        month_ten = 2'd0; month_unit = 4'd2; day_ten = 2'd2; day_unit = 4'd9;
        hour_ten = 2'd2; hour_unit = 4'd3; min_ten = 4'd5; min_unit = 4'd9;
        sec_ten = 4'd5; sec_unit = 4'd8;

        // Reset state and quiet idle line
        #12;
        check("rst_tx", {31'b0, tx}, 32'd1);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        ok = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) ok = 1'b0;
        end
        check("idle_100", {31'b0, ok}, 32'd1);

        // Full frame: busy length, done pulse, first-character bit timing
        push_frame();
        pulse_send();
        cnt = 0;
        while (busy === 1'b1 && cnt < 5000) begin
            if (cnt < 160) wave[cnt] = tx;
            cnt++;
            @(negedge clk);
        end
        check("busy_cycles", cnt, 32'd3360);
        check("done_pulse", {31'b0, done}, 32'd1);
        @(negedge clk);
        check("done_width", {31'b0, done}, 32'd0);
        frm = {1'b1, 8'h32, 1'b0};
        for (int i = 0; i < 10; i++)
            check("bit_timing", {16'b0, wave[i*16 +: 16]}, {16'b0, {16{frm[i]}}});

        // Snapshot: inputs change mid-frame without effect
        push_frame();
        pulse_send();
        repeat (49) @(negedge clk);
        sec_unit = 4'd9; year_unit = 4'd5;
        wait_idle(4000);
        sec_unit = 4'd8; year_unit = 4'd4;

        // Requests during a frame are dropped
        push_frame();
        pulse_send();
        repeat (98) @(negedge clk);
        send = 1'b1; @(negedge clk); send = 1'b0;
        repeat (1899) @(negedge clk);
        send = 1'b1; @(negedge clk); send = 1'b0;
        wait_idle(4000);
        ok = 1'b1;
        repeat (400) begin
            @(negedge clk);
            if (busy !== 1'b0 || tx !== 1'b1) ok = 1'b0;
        end
        check("no_requeue", {31'b0, ok}, 32'd1);

        // Back-to-back: send during the done cycle
        push_frame(); push_frame();
        pulse_send();
        cnt = 0;
        while (done !== 1'b1 && cnt < 4000) begin
            @(negedge clk);
            cnt++;
        end
        check("done_seen", {31'b0, done}, 32'd1);
        check("gap_idle_tx", {31'b0, tx}, 32'd1);
        send = 1'b1;
        @(negedge clk); send = 1'b0;
        check("b2b_start", {31'b0, tx}, 32'd0);
        check("b2b_busy", {31'b0, busy}, 32'd1);
        wait_idle(4000);

        // Non-BCD minute tens goes out as '<'
        min_ten = 4'hC;
        push_frame();
        pulse_send();
        wait_idle(4000);
        min_ten = 4'd5;

        // Reset in a zero data bit of character 7
        @(negedge clk);
        mon_en = 1'b0;
        pulse_send();
        repeat (1159) @(negedge clk);
        check("pre_rst_tx", {31'b0, tx}, 32'd0);
        check("pre_rst_busy", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_tx", {31'b0, tx}, 32'd1);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_done", {31'b0, done}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        ok = 1'b1;
        repeat (300) begin
            @(negedge clk);
            if (busy !== 1'b0 || tx !== 1'b1 || done !== 1'b0) ok = 1'b0;
        end
        check("post_rst_quiet", {31'b0, ok}, 32'd1);
        mon_en = 1'b1;

        // Block recovers after reset
        push_frame();
        pulse_send();
        wait_idle(4000);

        repeat (200) @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
